// File: rtl/ysyx_22041752_csru.sv
// Machine-mode CSR unit: CSR read-modify-write, trap entry/MRET, interrupt
// prioritisation and the mcycle/minstret counters.
module ysyx_22041752_csru #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] HARTID = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            illegal_o,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic            int_ack,
  input  logic [XLEN-1:0] epc,
  input  logic            mret,
  input  logic            retire,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic            int_pending_o,
  output logic [3:0]      int_code_o,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

  logic            st_mie;
  logic            st_mpie;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus_fixed;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] irq_vec;
  logic [XLEN-1:0] irq_active;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] wr_val;
  logic            legal;
  logic            csr_wen;
  logic            trap_int;
  logic            trap_any;
  logic            mret_en;

  // Hardwired MPP=11 and, on RV64, UXL/SXL=2 in bits [35:32].
  generate
    if (XLEN == 64) begin : g_mstatus64
      assign mstatus_fixed = {{(XLEN-36){1'b0}}, 4'hA, 32'h0000_1800};
    end else begin : g_mstatus32
      assign mstatus_fixed = {{(XLEN-13){1'b0}}, 13'h1800};
    end
  endgenerate

  always_comb begin
    mstatus_val    = mstatus_fixed;
    mstatus_val[7] = st_mpie;
    mstatus_val[3] = st_mie;
    irq_vec        = '0;
    irq_vec[3]     = irq_msip;
    irq_vec[7]     = irq_mtip;
    irq_vec[11]    = irq_meip;
  end

  always_comb begin
    rdata = '0;
    legal = 1'b1;
    case (addr)
      A_MSTATUS:  rdata = mstatus_val;
      A_MIE:      rdata = mie;
      A_MTVEC:    rdata = mtvec;
      A_MSCRATCH: rdata = mscratch;
      A_MEPC:     rdata = mepc;
      A_MCAUSE:   rdata = mcause;
      A_MIP:      rdata = mip;
      A_MCYCLE:   rdata = mcycle;
      A_MINSTRET: rdata = minstret;
      A_MHARTID:  rdata = HARTID;
      default:    legal = 1'b0;
    endcase
  end

  assign illegal_o = (csr_op != 2'b00) && !legal;

  always_comb begin
    case (csr_op)
      2'b01:   wr_val = wdata;
      2'b10:   wr_val = rdata | wdata;
      2'b11:   wr_val = rdata & ~wdata;
      default: wr_val = rdata;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not write.
  assign csr_wen = (csr_op != 2'b00) && legal && ((csr_op == 2'b01) || (wdata != '0));

  assign irq_active    = mie & mip;
  assign int_pending_o = st_mie && (irq_active != '0);

  always_comb begin
    if (!int_pending_o)     int_code_o = 4'd0;
    else if (irq_active[11]) int_code_o = 4'd11;
    else if (irq_active[3])  int_code_o = 4'd3;
    else                     int_code_o = 4'd7;
  end

  assign trap_int = int_ack && int_pending_o && !exc_valid;
  assign trap_any = exc_valid || trap_int;
  assign mret_en  = mret && !trap_any;

  assign trap_base  = {mtvec[XLEN-1:2], 2'b00};
  assign trap_vec_o = (mtvec[0] && trap_int) ? trap_base + XLEN'({int_code_o, 2'b00}) : trap_base;
  assign mepc_o     = mepc;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie      <= '0;
      mip      <= '0;
      mtvec    <= MTVEC_RST & ~XLEN'(2);
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mip      <= irq_vec;
      mcycle   <= mcycle + 1'b1;
      minstret <= minstret + XLEN'(retire);

      if (trap_any) begin
        mepc    <= epc & ~XLEN'(1);
        mcause  <= {trap_int, {(XLEN-5){1'b0}}, (trap_int ? int_code_o : exc_code)};
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_en) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end

      // Later assignments override the trap/increment updates above only
      // where the register is not claimed by a higher-priority action.
      if (csr_wen) begin
        case (addr)
          A_MSTATUS: begin
            if (!trap_any && !mret) begin
              st_mie  <= wr_val[3];
              st_mpie <= wr_val[7];
            end
          end
          A_MIE:      mie      <= wr_val & IRQ_MASK;
          A_MTVEC:    mtvec    <= wr_val & ~XLEN'(2);
          A_MSCRATCH: mscratch <= wr_val;
          A_MEPC:     if (!trap_any) mepc <= wr_val & ~XLEN'(1);
          A_MCAUSE:   if (!trap_any) mcause <= wr_val;
          A_MCYCLE:   mcycle   <= wr_val;
          A_MINSTRET: minstret <= wr_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_csru.sv
// Bench for the CSR unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the CSR file.
module tb_ysyx_22041752_csru;

  localparam logic [63:0] MTVEC_RST = 64'h100;
  localparam logic [63:0] HARTID    = 64'h5;

  logic        clk;
  logic        reset;
  logic [1:0]  csr_op;
  logic [11:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        illegal_o;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic        int_ack;
  logic [63:0] epc;
  logic        mret;
  logic        retire;
  logic        irq_msip, irq_mtip, irq_meip;
  logic        int_pending_o;
  logic [3:0]  int_code_o;
  logic [63:0] trap_vec_o;
  logic [63:0] mepc_o;

  ysyx_22041752_csru #(.XLEN(64), .MTVEC_RST(MTVEC_RST), .HARTID(HARTID)) dut (
    .clk(clk), .reset(reset), .csr_op(csr_op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .illegal_o(illegal_o), .exc_valid(exc_valid), .exc_code(exc_code),
    .int_ack(int_ack), .epc(epc), .mret(mret), .retire(retire),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .int_pending_o(int_pending_o), .int_code_o(int_code_o),
    .trap_vec_o(trap_vec_o), .mepc_o(mepc_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural state of the model.
  bit          m_st_mie, m_st_mpie;
  logic [63:0] m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

  function automatic bit m_legal(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h344, 12'hB00, 12'hB02, 12'hF14};
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'hA_0000_1800 | {56'b0, m_st_mpie, 3'b0, m_st_mie, 3'b0};
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return HARTID;
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit m_pending();
    return m_st_mie && ((m_mie & m_mip) != 64'h0);
  endfunction

  function automatic logic [3:0] m_code();
    logic [63:0] act;
    act = m_mie & m_mip;
    if (!m_pending()) return 4'd0;
    if (act[11]) return 4'd11;
    if (act[3])  return 4'd3;
    return 4'd7;
  endfunction

  function automatic logic [63:0] m_trap_vec();
    logic [63:0] base;
    base = m_mtvec & ~64'h3;
    if (m_mtvec[0] && int_ack && !exc_valid && m_pending())
      return base + 64'(m_code()) * 64'd4;
    return base;
  endfunction

  task automatic model_step();
    logic [63:0] old, nv;
    logic [3:0]  code;
    bit ti, tr, mr, wen;
    if (reset) begin
      m_st_mie = 0; m_st_mpie = 0; m_mie = 0; m_mip = 0; m_mtvec = MTVEC_RST;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
      return;
    end
    code = m_code();
    ti   = !exc_valid && int_ack && m_pending();
    tr   = exc_valid || ti;
    mr   = mret && !tr;
    old  = m_read(addr);
    nv   = (csr_op == 2'd1) ? wdata : (csr_op == 2'd2) ? (old | wdata) : (old & ~wdata);
    wen  = (csr_op != 2'd0) && m_legal(addr) && (csr_op == 2'd1 || wdata != 64'h0);
    m_mcycle = m_mcycle + 1;
    if (retire) m_minstret = m_minstret + 1;
    m_mip = {52'b0, irq_meip, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};
    if (tr) begin
      m_mepc    = epc & ~64'h1;
      m_mcause  = ti ? ((64'h1 << 63) | 64'(code)) : 64'(exc_code);
      m_st_mpie = m_st_mie;
      m_st_mie  = 0;
    end else if (mr) begin
      m_st_mie  = m_st_mpie;
      m_st_mpie = 1;
    end
    if (wen) begin
      case (addr)
        12'h300: if (!tr && !mret) begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
        12'h304: m_mie = nv & 64'h888;
        12'h305: m_mtvec = nv & ~64'h2;
        12'h340: m_mscratch = nv;
        12'h341: if (!tr) m_mepc = nv & ~64'h1;
        12'h342: if (!tr) m_mcause = nv;
        12'hB00: m_mcycle = nv;
        12'hB02: m_minstret = nv;
        default: ;
      endcase
    end
  endtask

  // Compare process: outputs checked mid-cycle, then the model advances.
  always @(negedge clk) begin
    if (started) begin
      chk("rdata", rdata, m_read(addr));
      chk("illegal_o", illegal_o, (csr_op != 2'd0) && !m_legal(addr));
      chk("int_pending_o", int_pending_o, m_pending());
      chk("int_code_o", int_code_o, m_code());
      chk("trap_vec_o", trap_vec_o, m_trap_vec());
      chk("mepc_o", mepc_o, m_mepc);
    end
    model_step();
  end

  task automatic idle();
    csr_op = 0; exc_valid = 0; int_ack = 0; mret = 0; retire = 0;
  endtask

  task automatic adv();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_op = op; addr = a; wdata = d;
    @(negedge clk);
    adv();
  endtask

  task automatic expect_read(input string name, input logic [11:0] a, input logic [63:0] v);
    csr_op = 0; addr = a;
    @(negedge clk);
    chk(name, rdata, v);
    adv();
  endtask

  logic [11:0] addr_tab [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'hB80, 12'h301};

  initial begin
    reset = 1; idle(); addr = 0; wdata = 0; epc = 0; exc_code = 0;
    irq_msip = 0; irq_mtip = 0; irq_meip = 0;
    m_mtvec = MTVEC_RST;
    repeat (2) @(posedge clk);
    #1 reset = 0; started = 1;

    // Reset state
    addr = 12'h300;
    @(negedge clk);
    chk("rst_mstatus", rdata, 64'hA_0000_1800);
    chk("rst_pending", int_pending_o, 0);
    chk("rst_code", int_code_o, 0);
    chk("rst_illegal", illegal_o, 0);
    adv();
    expect_read("rst_hartid", 12'hF14, 64'h5);
    expect_read("rst_mtvec", 12'h305, 64'h100);
    csr_op = 1; addr = 12'h7C0; wdata = 64'hFF;
    @(negedge clk);
    chk("illegal_7c0", illegal_o, 1);
    adv();

    // Read-modify-write on mscratch; mepc bit0 forced low
    wr(1, 12'h340, 64'hF0);
    csr_op = 2; addr = 12'h340; wdata = 64'h0F;
    @(negedge clk); chk("rw_mscratch", rdata, 64'hF0); adv();
    csr_op = 3; addr = 12'h340; wdata = 64'h3;
    @(negedge clk); chk("rs_mscratch", rdata, 64'hFF); adv();
    expect_read("rc_mscratch", 12'h340, 64'hFC);
    wr(1, 12'h341, 64'h8000_0003);
    expect_read("mepc_bit0", 12'h341, 64'h8000_0002);
    chk("mepc_o_bit0", mepc_o, 64'h8000_0002);

    // Timer interrupt latency
    wr(1, 12'h304, 64'h80);
    wr(2, 12'h300, 64'h8);
    irq_mtip = 1;
    @(negedge clk); chk("irq_lat_n", int_pending_o, 0); adv();
    @(negedge clk); chk("irq_lat_n1", int_pending_o, 1); chk("irq_code_mti", int_code_o, 7); adv();

    // Vectored trap entry and MRET
    wr(1, 12'h305, 64'h8000_0001);
    int_ack = 1; epc = 64'h8000_0044;
    @(negedge clk); chk("vec_code", int_code_o, 7); chk("vec_target", trap_vec_o, 64'h8000_001C); adv();
    @(negedge clk); chk("post_trap_pending", int_pending_o, 0); adv();
    expect_read("int_mcause", 12'h342, 64'h8000_0000_0000_0007);
    expect_read("trap_mstatus", 12'h300, 64'hA_0000_1880);
    expect_read("int_mepc", 12'h341, 64'h8000_0044);
    mret = 1;
    @(negedge clk); adv();
    expect_read("mret_mstatus", 12'h300, 64'hA_0000_1888);

    // External interrupt wins
    irq_meip = 1;
    wr(1, 12'h304, 64'h880);
    @(negedge clk); chk("irq_code_mei", int_code_o, 11); adv();

    // Exception beats int_ack and a concurrent mepc write
    exc_valid = 1; exc_code = 4'd11; epc = 64'h8000_0100; int_ack = 1;
    csr_op = 1; addr = 12'h341; wdata = 64'h1234;
    @(negedge clk); chk("exc_vec_direct", trap_vec_o, 64'h8000_0000); adv();
    expect_read("exc_mepc", 12'h341, 64'h8000_0100);
    expect_read("exc_mcause", 12'h342, 64'hB);

    // Counter wrap and write-over-increment
    wr(1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_read("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_read("mcycle_wrap", 12'hB00, 64'h0);
    csr_op = 1; addr = 12'hB02; wdata = 64'h5; retire = 1;
    @(negedge clk); adv();
    expect_read("minstret_wr", 12'hB02, 64'h5);
    addr = 12'hB02; retire = 1;
    @(negedge clk); chk("minstret_hold", rdata, 64'h5); adv();
    expect_read("minstret_inc", 12'hB02, 64'h6);

    // Randomized traffic, checked by the compare process every cycle
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      csr_op    = 2'($urandom_range(0, 3));
      addr      = addr_tab[$urandom_range(0, 12)];
      wdata     = ($urandom_range(0, 5) == 0) ? 64'h0 : {$urandom, $urandom};
      exc_valid = ($urandom_range(0, 29) == 0);
      exc_code  = 4'($urandom);
      int_ack   = ($urandom_range(0, 3) == 0);
      mret      = ($urandom_range(0, 19) == 0);
      retire    = 1'($urandom_range(0, 1));
      epc       = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) irq_msip = ~irq_msip;
      if ($urandom_range(0, 7) == 0) irq_mtip = ~irq_mtip;
      if ($urandom_range(0, 7) == 0) irq_meip = ~irq_meip;
      @(posedge clk); #1;
    end
    reset = 0; idle();
    @(negedge clk);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
